// File: rtl/stop_watch_ctrl.sv
// Stopwatch timing core: 00.0-99.9 BCD up/down counter with run/pause/done FSM
// and display encoding (dash on done, leading-zero blanking). Outputs depend only on registers.
module stop_watch_ctrl #(
  parameter int DVSR = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clr,
  input  logic        load,
  input  logic [11:0] preset,
  input  logic        up,
  output logic [4:0]  hex2,
  output logic [4:0]  hex1,
  output logic [4:0]  hex0,
  output logic [2:0]  dp_out,
  output logic [2:0]  en_out,
  output logic        running,
  output logic        done,
  output logic        ovf
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    d2, d1, d0, d2_n, d1_n, d0_n;
  logic          ovf_n;
  logic          tick;

  assign tick = (state == RUN) && (cnt == CW'(DVSR - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      d2    <= '0;
      d1    <= '0;
      d0    <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d2    <= d2_n;
      d1    <= d1_n;
      d0    <= d0_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d2_n    = d2;
    d1_n    = d1;
    d0_n    = d0;
    ovf_n   = ovf;

    if (state == RUN) begin
      cnt_n = tick ? '0 : cnt + CW'(1);
      if (tick) begin
        if (up) begin
          if (d0 != 4'd9) d0_n = d0 + 4'd1;
          else begin
            d0_n = 4'd0;
            if (d1 != 4'd9) d1_n = d1 + 4'd1;
            else begin
              d1_n = 4'd0;
              if (d2 != 4'd9) d2_n = d2 + 4'd1;
              else begin
                d2_n  = 4'd0;
                ovf_n = 1'b1;
              end
            end
          end
        end else if ({d2, d1, d0} == 12'h000) begin
          // Reaching zero by another path still terminates a down count.
          state_n = DONE;
        end else begin
          if (d0 != 4'd0) d0_n = d0 - 4'd1;
          else begin
            d0_n = 4'd9;
            if (d1 != 4'd0) d1_n = d1 - 4'd1;
            else begin
              d1_n = 4'd9;
              d2_n = d2 - 4'd1;
            end
          end
          if ({d2, d1, d0} == 12'h001) state_n = DONE;
        end
      end
    end

    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
      d2_n    = 4'd0;
      d1_n    = 4'd0;
      d0_n    = 4'd0;
      ovf_n   = 1'b0;
    end else if (load && state != RUN) begin
      state_n = IDLE;
      cnt_n   = '0;
      d2_n    = (preset[11:8] > 4'd9) ? 4'd9 : preset[11:8];
      d1_n    = (preset[7:4]  > 4'd9) ? 4'd9 : preset[7:4];
      d0_n    = (preset[3:0]  > 4'd9) ? 4'd9 : preset[3:0];
    end else if (start_stop) begin
      case (state)
        IDLE: if (up || {d2, d1, d0} != 12'h000) begin
          state_n = RUN;
          cnt_n   = '0;
        end
        RUN: if (state_n == RUN) begin
          // Pause freezes the divider unless this cycle is the tick itself.
          state_n = PAUSE;
          if (!tick) cnt_n = cnt;
        end
        PAUSE:   state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    hex2    = {1'b0, d2};
    hex1    = {1'b0, d1};
    hex0    = {1'b0, d0};
    dp_out  = 3'b010;
    en_out  = {(d2 != 4'd0), 2'b11};
    running = (state == RUN);
    done    = (state == DONE);
    if (state == DONE) begin
      hex2   = 5'b10001;
      hex1   = 5'b10001;
      hex0   = 5'b10001;
      dp_out = 3'b000;
      en_out = 3'b111;
    end
  end
endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with DVSR=4; checks sampled 1 time unit after clk rise.
module tb_stop_watch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_stop = 1'b0, clr = 1'b0, load = 1'b0, up = 1'b1;
  logic [11:0] preset = 12'h000;
  logic [4:0]  hex2, hex1, hex0;
  logic [2:0]  dp_out, en_out;
  logic        running, done, ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  stop_watch_ctrl #(.DVSR(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clr(clr), .load(load),
    .preset(preset), .up(up), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .en_out(en_out), .running(running), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic pulse_load(input logic [11:0] p);
    preset = p; load = 1'b1; step(1); load = 1'b0;
  endtask

  // Packs the visible display state for compact comparisons.
  function automatic logic [15:0] digits();
    return {1'b0, hex2, hex1, hex0};
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_dig"}, digits(), 16'h0000);
    chk({tag, "_en"}, {13'd0, en_out}, 16'h0003);
    chk({tag, "_dp"}, {13'd0, dp_out}, 16'h0002);
    chk({tag, "_rdo"}, {13'd0, running, done, ovf}, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk_idle_zero("in_reset");
    step(2);
    reset = 1'b1;
    step(1);
    chk_idle_zero("after_reset");

    // Up count: first tick 4 clocks after start, 01.0 after 40.
    up = 1'b1;
    pulse_ss();
    chk("run_flag", {15'd0, running}, 16'd1);
    step(3);
    chk("pre_tick", {11'd0, hex0}, 16'd0);
    step(1);
    chk("first_tick", {11'd0, hex0}, 16'd1);
    step(36);
    chk("cnt_10", digits(), {1'b0, 5'd0, 5'd1, 5'd0});
    chk("cnt_10_en", {13'd0, en_out}, 16'h0003);
    step(1);
    pulse_ss();
    chk("pause_run", {15'd0, running}, 16'd0);
    step(5);
    chk("pause_hold", digits(), {1'b0, 5'd0, 5'd1, 5'd0});
    pulse_ss();
    step(2);
    chk("resume_pre", {11'd0, hex0}, 16'd0);
    step(1);
    chk("resume_tick", {11'd0, hex0}, 16'd1);
    pulse_clr();
    chk_idle_zero("clr1");

    // Down start from zero is ignored.
    up = 1'b0;
    pulse_ss();
    chk("down_zero_ign", {14'd0, running, done}, 16'd0);

    // Wrap 99.9 -> 00.0 sets ovf and keeps running.
    pulse_load(12'h999);
    chk("ld999", digits(), {1'b0, 5'd9, 5'd9, 5'd9});
    chk("ld999_en", {13'd0, en_out}, 16'h0007);
    up = 1'b1;
    pulse_ss();
    step(3);
    chk("wrap_pre", digits(), {1'b0, 5'd9, 5'd9, 5'd9});
    step(1);
    chk("wrap_dig", digits(), 16'h0000);
    chk("wrap_flags", {13'd0, running, done, ovf}, 16'b101);
    pulse_clr();
    chk_idle_zero("clr2");

    // Down count to DONE.
    pulse_load(12'h002);
    up = 1'b0;
    pulse_ss();
    step(4);
    chk("down_001", digits(), {1'b0, 5'd0, 5'd0, 5'd1});
    step(4);
    chk("done_dig", digits(), {1'b0, 5'b10001, 5'b10001, 5'b10001});
    chk("done_en", {13'd0, en_out}, 16'h0007);
    chk("done_dp", {13'd0, dp_out}, 16'h0000);
    chk("done_flags", {14'd0, running, done}, 16'b01);
    pulse_ss();
    step(3);
    chk("done_ss_ign", {14'd0, running, done}, 16'b01);

    // Load in RUN ignored; clr+load+start_stop at 05.3 -> IDLE zero.
    pulse_load(12'h052);
    up = 1'b1;
    pulse_ss();
    step(4);
    chk("run_053", digits(), {1'b0, 5'd0, 5'd5, 5'd3});
    pulse_load(12'h777);
    chk("run_load_ign", digits(), {1'b0, 5'd0, 5'd5, 5'd3});
    chk("run_load_run", {15'd0, running}, 16'd1);
    preset = 12'h444; clr = 1'b1; load = 1'b1; start_stop = 1'b1;
    step(1);
    clr = 1'b0; load = 1'b0; start_stop = 1'b0;
    chk_idle_zero("triple");

    // Clamped preset, then asynchronous reset mid-interval.
    pulse_load(12'hAF3);
    chk("clamp", digits(), {1'b0, 5'd9, 5'd9, 5'd3});
    chk("clamp_en", {13'd0, en_out}, 16'h0007);
    pulse_ss();
    step(2);
    #2 reset = 1'b0;
    #1 chk_idle_zero("async_rst");
    step(6);
    chk_idle_zero("rst_held");
    reset = 1'b1;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/stop_watch_ctrl.md
Name: stop_watch_ctrl

Overview:
- Timing core of the three-digit stopwatch. It counts tenths of a second, 00.0 to 99.9, up or down, under start/stop, clear and preset control.
- It drives the 5-bit digit codes, decimal-point bits and digit-enable bits consumed directly by the downstream display multiplexer.
- Leading-zero blanking and the "done" dash pattern are generated here, so the multiplexer stays purely combinational.

Parameters:
- DVSR, 5_000_000, clk cycles per 0.1 s tick (50 MHz clock). Benches use 4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- clr  in  1  single-cycle pulse; zeroes count, returns to IDLE.
- load  in  1  single-cycle pulse; loads preset when not running.
- preset  in  12  BCD preset {d2,d1,d0}, 4 bits per digit.
- up  in  1  count direction: 1 = up, 0 = down; sampled at each tick.
- hex2, hex1, hex0  out  5 each  digit codes to the display mux.
- dp_out  out  3  decimal-point enables per digit, active-high.
- en_out  out  3  digit enables per digit, active-high; 0 = blank.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- ovf  out  1  sticky up-count wrap flag.

Behaviour:
- State registers: FSM, tick divider cnt (0..DVSR-1), BCD digits d2/d1/d0, ovf.
- Reset (reset=0, asynchronous): state IDLE, cnt=0, digits 0, ovf=0.
  - Outputs during reset: hex2/hex1/hex0=5'b00000, dp_out=3'b010, en_out=3'b011, running=0, done=0, ovf=0.
- Control priority when pulses coincide: clr > load > start_stop.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE + start_stop -> RUN, cnt=0.
    - Exception: up=0 and count=00.0 -> start_stop ignored, stay IDLE.
  - RUN + start_stop -> PAUSE; cnt holds its value.
  - PAUSE + start_stop -> RUN; cnt resumes from the held value (no restart).
  - Any state + clr -> IDLE; digits=0, cnt=0, ovf=0.
  - IDLE/PAUSE/DONE + load -> IDLE; digits=preset, cnt=0.
    - Each preset nibble >9 is clamped to 9.
    - ovf unchanged.
  - RUN + load -> ignored.
  - DONE + start_stop -> ignored; only clr or load leave DONE.
- Divider: increments only in RUN. At cnt=DVSR-1: tick asserted for that cycle, cnt -> 0.
- Tick actions (digits update on the clk edge ending the tick cycle; outputs are valid 1 cycle after the tick):
  - Up: BCD increment with ripple carry (d0 9->0 carries into d1; d1 9->0 carries into d2).
    - 99.9 -> 00.0, ovf set to 1, remains in RUN.
  - Down: BCD decrement with borrow.
    - Transition 00.1 -> 00.0 moves to DONE on the same edge.
- The up input is sampled only at ticks; changing it mid-interval has no effect until the next tick.
- start_stop in the same cycle as a tick: the tick update is applied and the state changes to PAUSE.
- Outputs are combinational from registers only, with no dependence on input pulses.
  - Non-DONE states: hexN = {1'b0, dN}; dp_out = 3'b010 (display reads d2d1.d0).
  - Leading-zero blanking: en_out[2] = (d2 != 0), en_out[1:0] = 2'b11 (00.0 shows as " 0.0").
  - DONE state: hex2/hex1/hex0 = 5'b10001 (dash), en_out = 3'b111, dp_out = 3'b000.
  - running = (state==RUN); done = (state==DONE).
- Reset asserted mid-count aborts immediately to the reset values; no tick is issued while reset is asserted.

Test Plan:
- Reset then release, DVSR=4 -> IDLE, hex2..hex0 = 0,0,0, en_out=3'b011, dp_out=3'b010, running=0.
- up=1, start_stop, run 40 clk -> count 01.0: hex1=1, hex0=0, en_out=3'b011; a new tick every 4 clk; pausing at cycle 41 holds 01.0 with cnt preserved.
- load preset=12'h999, up=1, start_stop, one tick -> digits 00.0, ovf=1, still running; clr -> ovf=0, IDLE.
- load preset=12'h002, up=0, start_stop, 8 clk -> 00.1 then DONE: hex codes all 5'b10001, en_out=3'b111, done=1; further start_stop ignored.
- Simultaneous clr+load+start_stop in RUN at 05.3 -> IDLE, digits 00.0, running=0.
- load preset=12'hAF3 -> digits 9,9,3, en_out=3'b111; reset deasserted→asserted mid-interval -> outputs return to reset values asynchronously.
